// File: rtl/music_seq_ctrl.sv
// Song sequencer: walks a synchronous note ROM one entry per tick and feeds
// left/right half-period divisors to the square-wave note generator.
module music_seq_ctrl #(
    parameter int TICK_DIV   = 12500000,
    parameter int SONG_LEN   = 512,
    parameter int ADDR_W     = 9,
    parameter int GAP_CYCLES = 1250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              repeat_en,
    input  logic              articulate,
    input  logic [1:0]        tempo_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [21:0]       rom_left,
    input  logic [21:0]       rom_right,
    output logic [21:0]       note_div_left,
    output logic [21:0]       note_div_right,
    output logic              playing,
    output logic              paused,
    output logic              done
);

    localparam int CNT_W = $clog2(2 * TICK_DIV + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    localparam logic [CNT_W-1:0]  LEN_NORM  = CNT_W'(TICK_DIV);
    localparam logic [CNT_W-1:0]  LEN_FAST  = CNT_W'(TICK_DIV / 2);
    localparam logic [CNT_W-1:0]  LEN_SLOW  = CNT_W'(TICK_DIV * 2);
    localparam logic [CNT_W-1:0]  GAP_LEN   = CNT_W'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  len_reg, len_next;
    logic [CNT_W-1:0]  tempo_len;
    logic              done_reg, done_next;
    logic              playing_reg, paused_reg;
    logic              load_en;
    logic              gap_next;
    logic [21:0]       rom_word [2];

    assign rom_word[0] = rom_left;
    assign rom_word[1] = rom_right;

    always_comb begin
        case (tempo_sel)
            2'd1:    tempo_len = LEN_FAST;
            2'd2:    tempo_len = LEN_SLOW;
            default: tempo_len = LEN_NORM;
        endcase
    end

    // Stop overrides everything; start only matters in IDLE, pause only in PLAY/PAUSE.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        done_next  = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
            addr_next  = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    addr_next = '0;
                    cnt_next  = '0;
                    if (start) state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    len_next   = tempo_len;
                    cnt_next   = '0;
                    state_next = ST_PLAY;
                end
                ST_PLAY: begin
                    if (pause) begin
                        state_next = ST_PAUSE;
                    end else if (cnt_reg == len_reg - 1'b1) begin
                        cnt_next = '0;
                        if (addr_reg == LAST_ADDR) begin
                            addr_next = '0;
                            if (repeat_en) begin
                                state_next = ST_LOAD;
                            end else begin
                                state_next = ST_IDLE;
                                done_next  = 1'b1;
                            end
                        end else begin
                            addr_next  = addr_reg + 1'b1;
                            state_next = ST_LOAD;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (pause) state_next = ST_PLAY;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ROM data for the new address is valid by the end of LOAD.
    assign load_en  = (state_reg == ST_LOAD) && !stop;
    assign gap_next = articulate && (cnt_next >= len_next - GAP_LEN);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : chan
            logic [21:0] held_reg, held_next;
            logic [21:0] div_reg, div_next;

            assign held_next = load_en ? rom_word[gi] : held_reg;

            // A zero ROM entry is a rest; LOAD keeps the previous note to avoid a glitch.
            always_comb begin
                div_next = 22'd1;
                case (state_next)
                    ST_LOAD: div_next = div_reg;
                    ST_PLAY: begin
                        if (!gap_next && held_next != 22'd0) div_next = held_next;
                    end
                    default: div_next = 22'd1;
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    held_reg <= '0;
                    div_reg  <= 22'd1;
                end else begin
                    held_reg <= held_next;
                    div_reg  <= div_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            cnt_reg     <= '0;
            len_reg     <= LEN_NORM;
            done_reg    <= 1'b0;
            playing_reg <= 1'b0;
            paused_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            cnt_reg     <= cnt_next;
            len_reg     <= len_next;
            done_reg    <= done_next;
            playing_reg <= (state_next == ST_LOAD) || (state_next == ST_PLAY);
            paused_reg  <= (state_next == ST_PAUSE);
        end
    end

    assign rom_addr       = addr_reg;
    assign note_div_left  = chan[0].div_reg;
    assign note_div_right = chan[1].div_reg;
    assign playing        = playing_reg;
    assign paused         = paused_reg;
    assign done           = done_reg;

endmodule

// File: doc/music_seq_ctrl.md
Name: music_seq_ctrl

Overview:
- Song sequencer that drives the stereo square-wave note generator.
- Steps through a synchronous note ROM, one entry per tick, and presents the left/right half-period divisors to the note generator.
- Handles start/stop/pause, repeat, tempo selection and an articulation gap; outputs divisor 1 (silence) whenever nothing should sound.
- Sits between the button/switch debounce logic and the note generator in the audio top level.

Parameters:
- TICK_DIV, 12500000, clk cycles per note tick at nominal tempo (8 ticks/s at 100 MHz).
- SONG_LEN, 512, number of ROM entries in the song.
- ADDR_W, 9, ROM address width; must satisfy 2^ADDR_W >= SONG_LEN.
- GAP_CYCLES, 1250000, length of the silent tail of each tick when articulation is on; must be < TICK_DIV/2.

Ports:
- clk, input, 1, system clock (crystal).
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse: begin playback from entry 0.
- stop, input, 1, one-cycle pulse: abort playback and return to idle.
- pause, input, 1, one-cycle pulse: toggle between play and pause.
- repeat_en, input, 1, level: wrap to entry 0 after the last entry.
- articulate, input, 1, level: silence the last GAP_CYCLES of each tick.
- tempo_sel, input, 2, 0/3 = normal, 1 = fast (TICK_DIV/2), 2 = slow (TICK_DIV*2).
- rom_addr, output, ADDR_W, note ROM address.
- rom_left, input, 22, left divisor from ROM; valid 1 cycle after rom_addr.
- rom_right, input, 22, right divisor from ROM; same timing.
- note_div_left, output, 22, divisor to the note generator (1 = silence).
- note_div_right, output, 22, divisor to the note generator (1 = silence).
- playing, output, 1, high in LOAD or PLAY.
- paused, output, 1, high in PAUSE.
- done, output, 1, one-cycle pulse when a non-repeating song ends.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE; rom_addr=0; tick counter=0.
  - note_div_left/right=22'd1; playing=0; paused=0; done=0.
  - Reset asserted mid-song aborts immediately; no done pulse.
- All outputs are registered.
- States:
  - IDLE: outputs silent, rom_addr=0.
    - start -> LOAD.
  - LOAD (exactly 1 cycle): wait for ROM data.
    - Latch tick_len from tempo_sel: TICK_DIV, TICK_DIV>>1 or TICK_DIV<<1. tempo_sel changes take effect only at the next LOAD.
    - Go to PLAY. On that edge, latch rom_left/rom_right into held divisors and clear the tick counter.
  - PLAY: tick counter increments each cycle.
    - At tick_cnt == tick_len-1 with rom_addr < SONG_LEN-1: rom_addr+1 -> LOAD.
    - At tick_cnt == tick_len-1 with rom_addr == SONG_LEN-1 and repeat_en=1: rom_addr=0 -> LOAD.
    - At tick_cnt == tick_len-1 with rom_addr == SONG_LEN-1 and repeat_en=0: -> IDLE; done=1 for one cycle; rom_addr=0.
  - PAUSE: counter, rom_addr and held divisors frozen; outputs silent.
    - pause -> PLAY, resuming at the frozen tick count.
- Note period is exactly tick_len+1 cycles (tick_len in PLAY plus 1 in LOAD).
- Output divisors:
  - In PLAY: the held divisor, except forced to 1 when the held value is 0 (a 0 entry means rest).
  - In PLAY with articulate=1 and tick_cnt >= tick_len-GAP_CYCLES: both outputs 1.
  - In LOAD: the previous note's divisors are held (no glitch to silence).
  - In IDLE and PAUSE: both outputs 1.
- Priority in the same cycle: stop > start > pause.
  - stop in any state -> IDLE next cycle; rom_addr=0; outputs 1; no done.
  - start in LOAD/PLAY/PAUSE is ignored.
  - pause in IDLE/LOAD is ignored.
- A repeat_en change is evaluated only at the last-entry boundary.

Test Plan (TICK_DIV=8, SONG_LEN=4, GAP_CYCLES=2, ROM entries L/R = {100/200, 0/300, 150/150, 400/0}):
- Reset then start pulse -> LOAD 1 cycle; note_div = 100/200 for the next 9 cycles; then 1/300, 150/150, 400/1; done pulses 1 cycle after entry 3's tick; outputs return to 1/1 and playing=0.
- repeat_en=1 over a full song -> after entry 3, rom_addr wraps to 0 and 100/200 plays again; no done pulse.
- pause pulse at tick_cnt=3 of entry 1 -> outputs 1/1, paused=1 for 20 cycles; second pause -> 1/300 resumes and lasts the remaining 5 cycles before LOAD.
- articulate=1, tempo_sel=0 -> per entry: 6 cycles of divisor, 2 cycles of 1/1, then 1 LOAD cycle holding the previous values.
- tempo_sel=1 set mid-entry 0 -> entry 0 keeps 8+1 cycles; entry 1 lasts 4+1; tempo_sel=2 gives 16+1.
- stop and pause in the same cycle during PLAY -> IDLE next cycle, outputs 1/1, rom_addr=0, no done; rst low mid-PAUSE -> all reset values asynchronously.
